// File: rtl/fetch_prefetch_if.sv
// Instruction-fetch bundle between fetch_prefetch and its neighbours.
//   master : the fetch stage (drives the memory request and the decode-side head).
//   slave  : the environment (instruction memory, branch unit and decode).
// Signals:
//   instr_req_out / instr_addr_out      fetch request and address
//   gnt_in                              request accepted this cycle
//   instr_rvalid_in / instr_rdata_in    in-order response
//   branch_mispredicted_in / pc_in      redirect strobe and target
//   instr_valid_out / instr_ready_in    decode handshake
//   instr_out / pc_out / opc            head instruction, its PC, its opcode field
interface fetch_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              instr_req_out;
  logic [ADDR_W-1:0] instr_addr_out;
  logic              gnt_in;
  logic              instr_rvalid_in;
  logic [DATA_W-1:0] instr_rdata_in;
  logic              branch_mispredicted_in;
  logic [ADDR_W-1:0] pc_in;
  logic              instr_valid_out;
  logic              instr_ready_in;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic [6:0]        opc;

  modport master (
    output instr_req_out, instr_addr_out,
    input  gnt_in, instr_rvalid_in, instr_rdata_in,
    input  branch_mispredicted_in, pc_in,
    output instr_valid_out,
    input  instr_ready_in,
    output instr_out, pc_out, opc
  );

  modport slave (
    input  instr_req_out, instr_addr_out,
    output gnt_in, instr_rvalid_in, instr_rdata_in,
    output branch_mispredicted_in, pc_in,
    input  instr_valid_out,
    output instr_ready_in,
    input  instr_out, pc_out, opc
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage with an in-order prefetch FIFO and several
// outstanding bus requests. Sequential fetches are issued while
// (FIFO entries + requests in flight) < DEPTH; returned words are stored with
// their PC and offered to decode over valid/ready. A branch redirect empties
// the FIFO, marks every in-flight request as stale and restarts at pc_in.
// Ports:
//   req    : clock, all state updates on its rising edge
//   reset  : asynchronous, active-low reset
//   bus    : fetch_prefetch_if.master (memory port, redirect, decode handshake)
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetch_cnt   : 32-bit count of instructions popped by decode
//   perf_discard_cnt : 32-bit count of dropped (stale) responses
module fetch_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              req,
  input  logic              reset,
  fetch_prefetch_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_discard_cnt
`endif
);
  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam int                PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d   [DEPTH];

  logic [CNT_W:0] in_use;
  logic           redirect, grant, drop, push, pop, head_vld;

  always_comb begin
    redirect = bus.branch_mispredicted_in;
    in_use   = {1'b0, count_q} + {1'b0, outstanding_q};
    head_vld = (count_q != '0);
    // Gated by reset so the request is low while reset is held.
    bus.instr_req_out  = reset && !redirect && (in_use < (CNT_W + 1)'(DEPTH));
    bus.instr_addr_out = fetch_pc_q;
    grant = bus.instr_req_out && bus.gnt_in;
    // A response is stale if older requests are still marked, or if it
    // arrives in the very cycle of a redirect.
    drop  = bus.instr_rvalid_in && ((discard_q != '0) || redirect);
    push  = bus.instr_rvalid_in && !drop;
    pop   = head_vld && bus.instr_ready_in && !redirect;

    bus.instr_valid_out = head_vld;
    bus.instr_out       = head_vld ? mem_data_q[rd_ptr_q] : '0;
    bus.pc_out          = head_vld ? mem_pc_q[rd_ptr_q]   : '0;
    bus.opc             = bus.instr_out[6:0];
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(bus.instr_rvalid_in);
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mem_data_d    = mem_data_q;
    mem_pc_d      = mem_pc_q;

    if (grant) fetch_pc_d = fetch_pc_q + STEP;
    if (bus.instr_rvalid_in && (discard_q != '0)) discard_d = discard_q - 1'b1;

    if (push) begin
      mem_data_d[wr_ptr_q] = bus.instr_rdata_in;
      mem_pc_d[wr_ptr_q]   = resp_pc_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
      resp_pc_d            = resp_pc_q + STEP;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect: everything still in flight after this edge is stale.
    if (redirect) begin
      fetch_pc_d = bus.pc_in;
      resp_pc_d  = bus.pc_in;
      discard_d  = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage is masked by count_q at the output, so it needs no reset.
  always_ff @(posedge req) begin
    mem_data_q <= mem_data_d;
    mem_pc_q   <= mem_pc_d;
  end

  // The credit check keeps the FIFO from overflowing on an accepted response.
  assert property (@(posedge req) disable iff (!reset)
                   !(push && (count_q == CNT_W'(DEPTH))))
    else $error("fetch_prefetch: push into full FIFO");

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_discard_q, perf_discard_d;

  always_comb begin
    perf_fetch_d   = perf_fetch_q + 32'(pop);
    perf_discard_d = perf_discard_q + 32'(drop);
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      perf_fetch_q   <= perf_fetch_d;
      perf_discard_q <= perf_discard_d;
    end
  end

  assign perf_fetch_cnt   = perf_fetch_q;
  assign perf_discard_cnt = perf_discard_q;
`endif
endmodule
